// File: rtl/mul4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul4_pkg
//  Purpose  : Shared definitions for the 2x2-bit multiplier fitness scorer:
//             default lane count, FSM state type and the reference product
//             function used by the lane comparator.
//  Revision : 1.0 - initial release
// ============================================================================
package mul4_pkg;

    // Number of bit-sliced test lanes carried per beat unless overridden.
    localparam int c_lanes_default = 16;

    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    // True 4-bit product of two 2-bit unsigned operands (max 3*3 = 9).
    function automatic logic [3:0] exp_prod(input logic [1:0] a, input logic [1:0] b);
        return {2'b00, a} * {2'b00, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul4_lane_match.sv
`default_nettype none
// ============================================================================
//  Module   : mul4_lane_match
//  Purpose  : Combinational per-beat scorer. For every lane it forms the true
//             product of the bit-sliced operands, compares it bitwise with
//             the candidate result and reports how many bits and how many
//             whole lanes matched.
//  Ports    : a1,a0,b1,b0 [LANES] - operand lanes, a={a1,a0}, b={b1,b0}
//             y3..y0      [LANES] - candidate result lanes
//             bit_inc     [BIT_W] - matching result bits over all lanes
//             lane_inc    [LANE_W]- lanes with all four bits matching
//  Revision : 1.0 - initial release
// ============================================================================
module mul4_lane_match
    import mul4_pkg::*;
#(
    parameter int LANES  = c_lanes_default,
    parameter int BIT_W  = $clog2(4*LANES+1),
    parameter int LANE_W = $clog2(LANES+1)
) (
    input  logic [LANES-1:0]  a1,
    input  logic [LANES-1:0]  a0,
    input  logic [LANES-1:0]  b1,
    input  logic [LANES-1:0]  b0,
    input  logic [LANES-1:0]  y3,
    input  logic [LANES-1:0]  y2,
    input  logic [LANES-1:0]  y1,
    input  logic [LANES-1:0]  y0,
    output logic [BIT_W-1:0]  bit_inc,
    output logic [LANE_W-1:0] lane_inc
);

    // Per-lane match mask: a set bit means that result bit is correct.
    logic [3:0] w_match [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [3:0] w_prod;
            logic [3:0] w_res;
            assign w_prod      = exp_prod({a1[gi], a0[gi]}, {b1[gi], b0[gi]});
            assign w_res       = {y3[gi], y2[gi], y1[gi], y0[gi]};
            assign w_match[gi] = ~(w_res ^ w_prod);
        end
    endgenerate

    always_comb begin
        bit_inc  = '0;
        lane_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            bit_inc  = bit_inc + BIT_W'(w_match[i][0]) + BIT_W'(w_match[i][1])
                               + BIT_W'(w_match[i][2]) + BIT_W'(w_match[i][3]);
            lane_inc = lane_inc + LANE_W'(&w_match[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul4_fitness_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : mul4_fitness_scorer
//  Purpose  : Accumulates bit-level and lane-level match scores of evolved
//             2x2-bit multiplier candidates over a multi-beat evaluation and
//             presents a held fitness report through a valid/ready handshake.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready/in_last - beat handshake, last marks final beat
//             a1,a0,b1,b0,y3..y0 [LANES] - operand and candidate result lanes
//             out_valid/out_ready        - report handshake
//             score_bits, score_lanes [ACC_W], beats [CNT_W] - report fields,
//             zero whenever no report is held
//  Revision : 1.0 - initial release
// ============================================================================
module mul4_fitness_scorer
    import mul4_pkg::*;
#(
    parameter int LANES = c_lanes_default,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [LANES-1:0] a1,
    input  logic [LANES-1:0] a0,
    input  logic [LANES-1:0] b1,
    input  logic [LANES-1:0] b0,
    input  logic [LANES-1:0] y3,
    input  logic [LANES-1:0] y2,
    input  logic [LANES-1:0] y1,
    input  logic [LANES-1:0] y0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] score_bits,
    output logic [ACC_W-1:0] score_lanes,
    output logic [CNT_W-1:0] beats
);

    localparam int c_bit_w  = $clog2(4*LANES+1);
    localparam int c_lane_w = $clog2(LANES+1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_bit_w-1:0]  w_bit_inc;
    logic [c_lane_w-1:0] w_lane_inc;

    logic [ACC_W-1:0]    r_acc_bits;
    logic [ACC_W-1:0]    r_acc_lanes;
    logic [CNT_W-1:0]    r_acc_beats;

    logic [ACC_W-1:0]    r_rep_bits;
    logic [ACC_W-1:0]    r_rep_lanes;
    logic [CNT_W-1:0]    r_rep_beats;

    logic                w_accept;
    logic [ACC_W:0]      w_bits_sum;
    logic [ACC_W:0]      w_lanes_sum;
    logic [ACC_W-1:0]    w_bits_sat;
    logic [ACC_W-1:0]    w_lanes_sat;
    logic [CNT_W-1:0]    w_beats_sat;

    mul4_lane_match #(
        .LANES  (LANES),
        .BIT_W  (c_bit_w),
        .LANE_W (c_lane_w)
    ) u_lane_match (
        .a1       (a1),
        .a0       (a0),
        .b1       (b1),
        .b0       (b0),
        .y3       (y3),
        .y2       (y2),
        .y1       (y1),
        .y0       (y0),
        .bit_inc  (w_bit_inc),
        .lane_inc (w_lane_inc)
    );

    // ------------------------------------------------------------------
    // FSM: in_ready / out_valid decode from the state register only, so
    // there is no combinational path from out_ready to in_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    assign w_accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Saturating accumulation: one extra carry bit detects overflow and
    // pins the result at all-ones instead of wrapping.
    // ------------------------------------------------------------------
    assign w_bits_sum  = {1'b0, r_acc_bits}  + (ACC_W+1)'(w_bit_inc);
    assign w_lanes_sum = {1'b0, r_acc_lanes} + (ACC_W+1)'(w_lane_inc);
    assign w_bits_sat  = w_bits_sum[ACC_W]  ? '1 : w_bits_sum[ACC_W-1:0];
    assign w_lanes_sat = w_lanes_sum[ACC_W] ? '1 : w_lanes_sum[ACC_W-1:0];
    assign w_beats_sat = (&r_acc_beats) ? r_acc_beats : r_acc_beats + CNT_W'(1);

    // The last beat's sums go straight to the report registers while the
    // accumulators clear, so the next evaluation starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_bits  <= '0;
            r_acc_lanes <= '0;
            r_acc_beats <= '0;
            r_rep_bits  <= '0;
            r_rep_lanes <= '0;
            r_rep_beats <= '0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc_bits  <= '0;
                r_acc_lanes <= '0;
                r_acc_beats <= '0;
                r_rep_bits  <= w_bits_sat;
                r_rep_lanes <= w_lanes_sat;
                r_rep_beats <= w_beats_sat;
            end else begin
                r_acc_bits  <= w_bits_sat;
                r_acc_lanes <= w_lanes_sat;
                r_acc_beats <= w_beats_sat;
            end
        end
    end

    assign score_bits  = (r_state == REPORT) ? r_rep_bits  : '0;
    assign score_lanes = (r_state == REPORT) ? r_rep_lanes : '0;
    assign beats       = (r_state == REPORT) ? r_rep_beats : '0;

endmodule
`default_nettype wire

// File: tb/tb_mul4_fitness_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul4_fitness_scorer
//  Purpose  : Self-checking bench for mul4_fitness_scorer. Two instances share
//             one stimulus stream: the default configuration and an ACC_W=8
//             variant whose score accumulators saturate early.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul4_fitness_scorer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;

    logic        in_ready, out_valid;
    logic [15:0] score_bits, score_lanes;
    logic [7:0]  beats;

    logic        s8_in_ready, s8_out_valid;
    logic [7:0]  s8_bits, s8_lanes;
    logic [7:0]  s8_beats;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integer sums, saturated only on readout.
    int m_bits, m_lanes, m_beats;
    int e_bits, e_lanes, e_beats;

    always #5 clk = ~clk;

    mul4_fitness_scorer #(.LANES(16), .ACC_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .out_valid(out_valid), .out_ready(out_ready),
        .score_bits(score_bits), .score_lanes(score_lanes), .beats(beats)
    );

    mul4_fitness_scorer #(.LANES(16), .ACC_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s8_in_ready), .in_last(in_last),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .out_valid(s8_out_valid), .out_ready(out_ready),
        .score_bits(s8_bits), .score_lanes(s8_lanes), .beats(s8_beats)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic set_exhaustive();
        a0 = 16'hAAAA; a1 = 16'hCCCC; b0 = 16'hF0F0; b1 = 16'hFF00;
    endtask

    // Drive y3..y0 with the arithmetically correct product of each lane.
    task automatic set_correct();
        int a, b, p;
        for (int i = 0; i < 16; i++) begin
            a = 2*int'(a1[i]) + int'(a0[i]);
            b = 2*int'(b1[i]) + int'(b0[i]);
            p = a * b;
            y0[i] = p[0]; y1[i] = p[1]; y2[i] = p[2]; y3[i] = p[3];
        end
    endtask

    task automatic set_zero_y();
        y3 = '0; y2 = '0; y1 = '0; y0 = '0;
    endtask

    // Score the currently driven beat into the model.
    task automatic model_beat(input bit last);
        int a, b, p, y, mb;
        for (int i = 0; i < 16; i++) begin
            a  = 2*int'(a1[i]) + int'(a0[i]);
            b  = 2*int'(b1[i]) + int'(b0[i]);
            p  = a * b;
            y  = 8*int'(y3[i]) + 4*int'(y2[i]) + 2*int'(y1[i]) + int'(y0[i]);
            mb = 0;
            for (int k = 0; k < 4; k++)
                if (((y >> k) & 1) == ((p >> k) & 1)) mb++;
            m_bits += mb;
            if (mb == 4) m_lanes++;
        end
        m_beats++;
        if (last) begin
            e_bits = m_bits; e_lanes = m_lanes; e_beats = m_beats;
            m_bits = 0; m_lanes = 0; m_beats = 0;
        end
    endtask

    // Present the driven beat for one accepting edge (DUT must be in ACCUM).
    task automatic do_beat(input bit last);
        in_valid = 1'b1;
        in_last  = last;
        check("in_ready_accum", in_ready, 1);
        model_beat(last);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_report(input string tag);
        check({tag, "_out_valid"},   out_valid,    1);
        check({tag, "_in_ready"},    in_ready,     0);
        check({tag, "_bits"},        score_bits,   sat(e_bits, 16));
        check({tag, "_lanes"},       score_lanes,  sat(e_lanes, 16));
        check({tag, "_beats"},       beats,        sat(e_beats, 8));
        check({tag, "_s8_valid"},    s8_out_valid, 1);
        check({tag, "_s8_bits"},     s8_bits,      sat(e_bits, 8));
        check({tag, "_s8_lanes"},    s8_lanes,     sat(e_lanes, 8));
        check({tag, "_s8_beats"},    s8_beats,     sat(e_beats, 8));
    endtask

    task automatic release_report(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, out_valid,  0);
        check({tag, "_rel_ready"}, in_ready,   1);
        check({tag, "_rel_bits"},  score_bits, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        a1 = '0; a0 = '0; b1 = '0; b0 = '0; set_zero_y();
        m_bits = 0; m_lanes = 0; m_beats = 0;
        e_bits = 0; e_lanes = 0; e_beats = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,    1);
        check("rst_out_valid", out_valid,   0);
        check("rst_bits",      score_bits,  0);
        check("rst_lanes",     score_lanes, 0);
        check("rst_beats",     beats,       0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single correct beat over every operand pair.
        set_exhaustive(); set_correct();
        do_beat(1'b1);
        check_report("t1");
        check("t1_lit_bits", score_bits, 64);
        check("t1_lit_lanes", score_lanes, 16);
        check("t1_lit_beats", beats, 1);
        release_report("t1");

        // All-zero candidate.
        set_exhaustive(); set_zero_y();
        do_beat(1'b1);
        check_report("t2");
        check("t2_lit_bits", score_bits, 50);
        check("t2_lit_lanes", score_lanes, 7);
        release_report("t2");

        // Three beats: correct, zero, correct.
        set_exhaustive(); set_correct(); do_beat(1'b0);
        set_zero_y();                    do_beat(1'b0);
        set_correct();                   do_beat(1'b1);
        check_report("t3");
        check("t3_lit_bits", score_bits, 178);
        check("t3_lit_lanes", score_lanes, 39);
        check("t3_lit_beats", beats, 3);
        release_report("t3");

        // Five correct beats: the 8-bit bit-score saturates.
        set_exhaustive(); set_correct();
        for (int i = 0; i < 5; i++) do_beat(i == 4);
        check_report("t4");
        check("t4_lit_s8_bits", s8_bits, 255);
        check("t4_lit_s8_lanes", s8_lanes, 80);
        check("t4_lit_s8_beats", s8_beats, 5);
        release_report("t4");

        // Report held with back-pressure while a beat waits upstream.
        set_exhaustive(); set_correct();
        do_beat(1'b1);
        in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid,   1);
            check("hold_ready", in_ready,    0);
            check("hold_bits",  score_bits,  64);
            check("hold_lanes", score_lanes, 16);
            check("hold_beats", beats,       1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_rel_valid", out_valid, 0);
        do_beat(1'b1);
        check_report("t5");
        check("t5_lit_beats", beats, 1);
        release_report("t5");

        // Reset mid-evaluation discards partial sums.
        set_exhaustive(); set_correct();
        do_beat(1'b0); do_beat(1'b0);
        rst_n = 1'b0;
        m_bits = 0; m_lanes = 0; m_beats = 0;
        #2;
        check("mrst_in_ready",  in_ready,    1);
        check("mrst_out_valid", out_valid,   0);
        check("mrst_bits",      score_bits,  0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_no_spurious", out_valid, 0);
        set_zero_y();
        do_beat(1'b1);
        check_report("t6");
        check("t6_lit_bits", score_bits, 50);
        check("t6_lit_lanes", score_lanes, 7);
        check("t6_lit_beats", beats, 1);
        release_report("t6");

        // Randomized evaluations with idle gaps and report back-pressure.
        for (int ev = 0; ev < 30; ev++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int bt = 0; bt < len; bt++) begin
                a1 = 16'($urandom); a0 = 16'($urandom);
                b1 = 16'($urandom); b0 = 16'($urandom);
                set_correct();
                if ($urandom_range(0, 1) == 1) begin
                    y3 ^= 16'($urandom & $urandom); y2 ^= 16'($urandom & $urandom);
                    y1 ^= 16'($urandom & $urandom); y0 ^= 16'($urandom & $urandom);
                end
                do_beat(bt == len - 1);
                repeat ($urandom_range(0, 2)) begin
                    if (bt != len - 1) begin
                        @(posedge clk); #1;
                    end
                end
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            check_report("rnd");
            release_report("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul4_fitness_scorer.md
# mul4_fitness_scorer

Downstream scoring stage for evolved 2x2-bit multiplier candidates. It accepts beats of bit-sliced operand lanes (a1, a0, b1, b0) together with the candidate's four output lanes (y3..y0). Each beat it computes the true product per lane, counts matching output bits and fully correct lanes, and accumulates both counts over a multi-beat evaluation. At the end of an evaluation it presents a held fitness report through a valid/ready handshake.

## Interface
Parameters:
- LANES, 16, number of bit-sliced test lanes per beat (width of every vector port)
- ACC_W, 16, width of the bit-score and lane-score accumulators (saturating)
- CNT_W, 8, width of the beat counter (saturating)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present
- in_ready  out  1  block can accept a beat
- in_last  in  1  accepted beat is the final beat of the evaluation
- a1, a0, b1, b0  in  LANES  operand lanes; lane i operands are a={a1[i],a0[i]} and b={b1[i],b0[i]}
- y3, y2, y1, y0  in  LANES  candidate output lanes; lane i result is {y3[i],y2[i],y1[i],y0[i]}
- out_valid  out  1  report held
- out_ready  in  1  consumer takes report
- score_bits  out  ACC_W  accumulated matching output bits
- score_lanes  out  ACC_W  accumulated lanes with all 4 bits correct
- beats  out  CNT_W  accepted beats in this evaluation

## Operation
- States: ACCUM and REPORT. Reset enters ACCUM with all accumulators at zero.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - A beat is accepted on in_valid & in_ready.
  - Per lane: p = a*b, a 4-bit unsigned value (max 9); m = ~(y ^ p).
  - bit_inc = popcount of m over all lanes, range 0..4*LANES.
  - lane_inc = number of lanes whose m is 4'b1111, range 0..LANES.
  - Accumulators update as acc_bits += bit_inc, acc_lanes += lane_inc, beats += 1.
  - Each accumulator saturates at all-ones and never wraps.
- Accepted beat with in_last=1:
  - The final sums (including that beat) are copied to the report registers.
  - The state moves to REPORT.
  - The accumulators clear to zero in the same edge.
- REPORT:
  - in_ready=0 and out_valid=1.
  - score_bits, score_lanes and beats stay stable until out_ready=1.
  - out_valid & out_ready returns the state to ACCUM on the next edge.
- in_valid without acceptance (REPORT state) is ignored. Upstream must hold the beat.
- Single-beat evaluation (in_last on the first beat) is legal: beats=1.
- Reset mid-evaluation or mid-report discards all partial sums and the report. No spurious out_valid follows reset.
- Report outputs are zero outside REPORT.

## Timing
- Reset values: in_ready=1, out_valid=0, score_bits=0, score_lanes=0, beats=0.
- The per-beat compare is combinational, with one register stage into the accumulators.
- Latency: out_valid rises on the edge that accepts the last beat, so it is visible the cycle after.
- Throughput: one beat per cycle in ACCUM.
- REPORT lasts at least 1 cycle.
- Because in_ready is low in REPORT, the next evaluation's first beat is accepted no earlier than the cycle after the out handshake.
- No combinational path from out_ready to in_ready. in_ready is decoded from the state register only.

## Structure
- Shared package mul4_pkg:
  - LANES default constant.
  - State enum {ACCUM, REPORT}.
  - Function exp_prod(a[1:0], b[1:0]) returning the 4-bit product.
- Sub-module mul4_lane_match:
  - Purely combinational.
  - Takes the 8 vector inputs and returns bit_inc and lane_inc.
  - Instantiated once.
- The top holds the FSM, the accumulators, the saturation logic and the report registers.

## Test plan
The exhaustive operand set used below is a0=16'hAAAA, a1=16'hCCCC, b0=16'hF0F0, b1=16'hFF00 (covers all 16 operand pairs).
- Exhaustive operand set, correct products, one beat with in_last=1 -> score_bits=64, score_lanes=16, beats=1, out_valid one cycle after acceptance.
- Same operands, y3..y0 all zero, one beat -> score_bits=50, score_lanes=7, beats=1.
- Three beats (correct, all-zero, correct) with last on the third -> score_bits=178, score_lanes=39, beats=3.
- ACC_W=8, five correct beats -> score_bits=255 (saturated, no wrap), score_lanes=80, beats=5.
- Report held 4 cycles with out_ready=0 and in_valid=1 -> outputs stable, in_ready=0, no beat counted. out_ready=1 then a new single correct beat -> fresh report of 64/16/1.
- rst_n pulsed low after two beats with no last -> all outputs at reset values. A following single all-zero beat -> 50/7/1.
